// File: rtl/sim_vector_driver_pkg.sv
// Shared state type, constants and LFSR/CRC step helpers for the simulation
// vector driver.
package sim_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] SIG_INIT  = 16'hFFFF;

  function automatic int words(input int n);
    return (n + 32'sd31) / 32'sd32;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] sh;
    sh = {1'b0, s[31:1]};
    return s[0] ? (sh ^ LFSR_MASK) : sh;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] sig, input logic bit_in);
    logic fb;
    fb = sig[15] ^ bit_in;
    return {sig[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sim_vector_driver_if.sv
// Harness-side bundle of the vector driver: run control, driven vector,
// circuit response and compacted result.
interface sim_vector_driver_if #(
  parameter int N_IN    = 230,
  parameter int COUNT_W = 16
);
  logic               start;
  logic [COUNT_W-1:0] num_vectors;
  logic [N_IN-1:0]    vec_out;
  logic               vec_valid;
  logic               f_in;
  logic               busy;
  logic               done;
  logic [15:0]        sig_out;
  logic [COUNT_W-1:0] ones_count;

  modport master (
    output start, num_vectors, f_in,
    input  vec_out, vec_valid, busy, done, sig_out, ones_count
  );

  modport slave (
    input  start, num_vectors, f_in,
    output vec_out, vec_valid, busy, done, sig_out, ones_count
  );
endinterface

// File: rtl/sim_vector_driver_lfsr32.sv
// 32-bit Galois LFSR with synchronous load (priority) and single-step advance.
module sim_lfsr32
  import sim_drv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] r_state;

  // Load wins over step; reset to a non-zero value so the sequence never locks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= 32'h0000_0001;
    end else if (load) begin
      r_state <= load_val;
    end else if (step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/sim_vector_driver.sv
// Drives LFSR-generated vectors into a combinational circuit, holds each for a
// settle time, and compacts the sampled f responses into a CRC-16 and ones-count.
module sim_vector_driver
  import sim_drv_pkg::*;
#(
  parameter int          N_IN    = 230,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int          LATENCY = 1,
  parameter int          COUNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  sim_vector_driver_if.slave bus
);

  localparam int                 WORDS     = words(N_IN);
  localparam logic [31:0]        SEED_EFF  = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;
  localparam int                 FCNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int                 WCNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(WORDS - 32'sd1);
  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(LATENCY - 32'sd1);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1'b1);

  state_e             r_state;
  logic [N_IN-1:0]    r_vf;
  logic [N_IN-1:0]    r_vec;
  logic               r_vec_valid;
  logic               r_busy;
  logic               r_done;
  logic [15:0]        r_sig;
  logic [COUNT_W-1:0] r_ones;
  logic [COUNT_W-1:0] r_remain;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [WCNT_W-1:0]  r_wcnt;

  logic [31:0]        w_lfsr;
  logic               w_load;
  logic               w_step;
  logic [N_IN+31:0]   w_cat;
  logic [N_IN-1:0]    w_vf_next;
  logic               w_unused;

  assign w_load    = (r_state == IDLE) && bus.start;
  assign w_step    = (r_state == FILL);
  assign w_cat     = {r_vf, w_lfsr};
  assign w_vf_next = w_cat[N_IN-1:0];
  // Bits shifted out of the top of the fill register are discarded
  assign w_unused  = ^w_cat[N_IN+31:N_IN];

  sim_lfsr32 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (SEED_EFF),
    .step     (w_step),
    .state    (w_lfsr)
  );

  // Run sequencing, fill shifting and response compaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vf        <= {N_IN{1'b0}};
      r_vec       <= {N_IN{1'b0}};
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sig       <= 16'h0000;
      r_ones      <= {COUNT_W{1'b0}};
      r_remain    <= {COUNT_W{1'b0}};
      r_fcnt      <= {FCNT_W{1'b0}};
      r_wcnt      <= {WCNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sig    <= SIG_INIT;
            r_ones   <= {COUNT_W{1'b0}};
            r_remain <= bus.num_vectors;
            r_fcnt   <= {FCNT_W{1'b0}};
            if (bus.num_vectors == {COUNT_W{1'b0}}) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= FILL;
              r_busy  <= 1'b1;
            end
          end
        end
        FILL: begin
          r_vf        <= w_vf_next;
          r_vec_valid <= 1'b0;
          if (r_fcnt == FCNT_LAST) begin
            r_vec       <= w_vf_next;
            r_vec_valid <= 1'b1;
            r_fcnt      <= {FCNT_W{1'b0}};
            r_wcnt      <= {WCNT_W{1'b0}};
            r_state     <= WAIT;
          end else begin
            r_fcnt <= r_fcnt + FCNT_W'(1'b1);
          end
        end
        WAIT: begin
          if (r_wcnt == WCNT_LAST) begin
            r_sig       <= crc16_step(r_sig, bus.f_in);
            r_ones      <= r_ones + COUNT_W'(bus.f_in);
            r_remain    <= r_remain - CNT_ONE;
            r_vec_valid <= 1'b0;
            if (r_remain == CNT_ONE) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= FILL;
            end
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1'b1);
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_vec_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_done      <= 1'b0;
          r_vec_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec_out    = r_vec;
  assign bus.vec_valid  = r_vec_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sig_out    = r_sig;
  assign bus.ones_count = r_ones;

endmodule

// File: tb/tb_sim_vector_driver.sv
// Self-checking bench for sim_vector_driver: three configurations, a table of
// directed runs, randomized runs against a reference model, and a mid-run reset.
`timescale 1ns/1ps
module tb_sim_vector_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sim_vector_driver_if #(.N_IN(32),  .COUNT_W(16)) bus_a ();
  sim_vector_driver_if #(.N_IN(230), .COUNT_W(16)) bus_b ();
  sim_vector_driver_if #(.N_IN(230), .COUNT_W(16)) bus_c ();

  sim_vector_driver #(.N_IN(32),  .SEED(32'h0000_0001), .LATENCY(1), .COUNT_W(16))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  sim_vector_driver #(.N_IN(230), .SEED(32'h0000_0001), .LATENCY(1), .COUNT_W(16))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  sim_vector_driver #(.N_IN(230), .SEED(32'h0000_0000), .LATENCY(2), .COUNT_W(16))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));

  int NIN_T [3] = '{32, 230, 230};
  int LAT_T [3] = '{1, 1, 2};

  logic [2:0]   start_v = 3'b000;
  logic [15:0]  num_v   = 16'd0;
  int           f_mode  = 0;
  logic [255:0] f_mask  = '0;

  logic [255:0] vec_w  [3];
  logic         vv_w   [3];
  logic         busy_w [3];
  logic         done_w [3];
  logic [15:0]  sig_w  [3];
  logic [15:0]  ones_w [3];

  // The circuit under test: constant 0, constant 1, or masked parity of the vector
  function automatic logic f_of(input int m, input logic [255:0] v, input logic [255:0] msk);
    if (m == 0) return 1'b0;
    else if (m == 1) return 1'b1;
    else return ^(v & msk);
  endfunction

  assign bus_a.start = start_v[0];
  assign bus_b.start = start_v[1];
  assign bus_c.start = start_v[2];
  assign bus_a.num_vectors = num_v;
  assign bus_b.num_vectors = num_v;
  assign bus_c.num_vectors = num_v;
  assign vec_w[0] = 256'(bus_a.vec_out);
  assign vec_w[1] = 256'(bus_b.vec_out);
  assign vec_w[2] = 256'(bus_c.vec_out);
  assign bus_a.f_in = f_of(f_mode, vec_w[0], f_mask);
  assign bus_b.f_in = f_of(f_mode, vec_w[1], f_mask);
  assign bus_c.f_in = f_of(f_mode, vec_w[2], f_mask);
  assign vv_w[0] = bus_a.vec_valid;  assign vv_w[1] = bus_b.vec_valid;  assign vv_w[2] = bus_c.vec_valid;
  assign busy_w[0] = bus_a.busy;     assign busy_w[1] = bus_b.busy;     assign busy_w[2] = bus_c.busy;
  assign done_w[0] = bus_a.done;     assign done_w[1] = bus_b.done;     assign done_w[2] = bus_c.done;
  assign sig_w[0] = bus_a.sig_out;   assign sig_w[1] = bus_b.sig_out;   assign sig_w[2] = bus_c.sig_out;
  assign ones_w[0] = bus_a.ones_count; assign ones_w[1] = bus_b.ones_count; assign ones_w[2] = bus_c.ones_count;

  int n_checks = 0;
  int n_fail   = 0;

  int           sel = 0;
  logic         vv_prev = 1'b0;
  logic [255:0] cap [$];
  logic [255:0] exp_q [$];
  int           vv_cnt = 0, busy_cnt = 0, done_cnt = 0;

  // Observe the selected instance: capture each new vector and count cycles
  always @(negedge clk) begin
    if (vv_w[sel] && !vv_prev) cap.push_back(vec_w[sel]);
    vv_prev = vv_w[sel];
    if (vv_w[sel])   vv_cnt++;
    if (busy_w[sel]) busy_cnt++;
    if (done_w[sel]) done_cnt++;
  end

  task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Reference: whole-run expected vectors, signature and ones-count
  task automatic model(input int n_in, input int num, input int fm, input logic [255:0] msk,
                       output logic [15:0] sig, output int ones);
    logic [31:0]  l;
    logic [255:0] v, nmask;
    logic         f, fb;
    int           nw;
    l = 32'h1; sig = 16'hFFFF; ones = 0; nw = (n_in + 31) / 32;
    nmask = (n_in >= 256) ? '1 : ((256'd1 << n_in) - 256'd1);
    exp_q.delete();
    for (int k = 0; k < num; k++) begin
      v = '0;
      for (int w = 0; w < nw; w++) begin
        v = (v << 32) | {224'd0, l};
        l = ref_lfsr(l);
      end
      v = v & nmask;
      exp_q.push_back(v);
      f = f_of(fm, v, msk);
      fb = sig[15] ^ f;
      sig = (sig << 1) ^ (fb ? 16'h1021 : 16'h0000);
      ones += int'(f);
    end
  endtask

  task automatic run(input int idx, input int num, input int poke, input bit poke_done, output int cyc);
    sel = idx; cap.delete(); vv_cnt = 0; busy_cnt = 0; done_cnt = 0;
    @(negedge clk);
    num_v = 16'(num);
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    cyc = 0;
    while (!done_w[idx] && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start_v[idx] = (cyc == poke);
    end
    start_v[idx] = poke_done;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    check("run_terminates", 256'(cyc < 2000), 256'd1);
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int idx; int num; int fm; int poke; bit pdone;
    int cyc; logic [15:0] sig; int ones; int busy; int vv;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int           cyc, eones, idx, num, nw, guard;
    logic [15:0]  esig;

    tbl[0] = '{0, 2, 0, -1, 1'b0,  4, 16'hCF9F, 0,  4, 2};
    tbl[1] = '{1, 1, 0, -1, 1'b0,  9, 16'hEFDF, 0,  9, 1};
    tbl[2] = '{1, 1, 1, -1, 1'b1,  9, 16'hFFFE, 1,  9, 1};
    tbl[3] = '{2, 3, 0,  5, 1'b1, 30, 16'h8F1F, 0, 30, 6};
    tbl[4] = '{0, 0, 0, -1, 1'b1,  0, 16'hFFFF, 0,  0, 0};
    tbl[5] = '{2, 0, 1, -1, 1'b0,  0, 16'hFFFF, 0,  0, 0};

    #2 rst = 1'b1;
    #20;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_vec%0d", i),  vec_w[i], 256'd0);
      check($sformatf("rst_vv%0d", i),   256'(vv_w[i]), 256'd0);
      check($sformatf("rst_busy%0d", i), 256'(busy_w[i]), 256'd0);
      check($sformatf("rst_done%0d", i), 256'(done_w[i]), 256'd0);
      check($sformatf("rst_sig%0d", i),  256'(sig_w[i]), 256'd0);
      check($sformatf("rst_ones%0d", i), 256'(ones_w[i]), 256'd0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      f_mode = tbl[t].fm;
      run(tbl[t].idx, tbl[t].num, tbl[t].poke, tbl[t].pdone, cyc);
      check($sformatf("t%0d_cycles", t), 256'(cyc), 256'(tbl[t].cyc));
      check($sformatf("t%0d_sig", t),    256'(sig_w[tbl[t].idx]), 256'(tbl[t].sig));
      check($sformatf("t%0d_ones", t),   256'(ones_w[tbl[t].idx]), 256'(tbl[t].ones));
      check($sformatf("t%0d_done", t),   256'(done_cnt), 256'd1);
      check($sformatf("t%0d_busy", t),   256'(busy_cnt), 256'(tbl[t].busy));
      check($sformatf("t%0d_vvcyc", t),  256'(vv_cnt), 256'(tbl[t].vv));
      if (tbl[t].idx == 0 && tbl[t].num == 2) begin
        check("t0_nvec", 256'(cap.size()), 256'd2);
        if (cap.size() >= 2) begin
          check("t0_vec0", cap[0], 256'h0000_0001);
          check("t0_vec1", cap[1], 256'h8020_0003);
        end
      end
    end

    for (int r = 0; r < 8; r++) begin
      idx = int'($urandom_range(0, 2));
      num = int'($urandom_range(1, 5));
      f_mode = int'($urandom_range(0, 2));
      for (int w = 0; w < 8; w++) f_mask[w*32 +: 32] = $urandom;
      nw = (NIN_T[idx] + 31) / 32;
      model(NIN_T[idx], num, f_mode, f_mask, esig, eones);
      run(idx, num, -1, 1'b0, cyc);
      check($sformatf("r%0d_cycles", r), 256'(cyc), 256'(num * (nw + LAT_T[idx])));
      check($sformatf("r%0d_sig", r),    256'(sig_w[idx]), 256'(esig));
      check($sformatf("r%0d_ones", r),   256'(ones_w[idx]), 256'(eones & 16'hFFFF));
      check($sformatf("r%0d_nvec", r),   256'(cap.size()), 256'(num));
      for (int k = 0; k < num && k < cap.size(); k++)
        check($sformatf("r%0d_vec%0d", r, k), cap[k], exp_q[k]);
    end

    // Asynchronous reset while vector 2 of 5 is under test on the default instance
    sel = 1; f_mode = 2;
    for (int w = 0; w < 8; w++) f_mask[w*32 +: 32] = $urandom;
    cap.delete(); done_cnt = 0;
    @(negedge clk);
    num_v = 16'd5;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    guard = 0;
    while (!(cap.size() == 2 && vv_w[1]) && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    check("rstmid_reached_wait2", 256'(guard < 500), 256'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_vec",  vec_w[1], 256'd0);
    check("rstmid_vv",   256'(vv_w[1]), 256'd0);
    check("rstmid_busy", 256'(busy_w[1]), 256'd0);
    check("rstmid_done", 256'(done_w[1]), 256'd0);
    check("rstmid_sig",  256'(sig_w[1]), 256'd0);
    check("rstmid_ones", 256'(ones_w[1]), 256'd0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("rstmid_no_done", 256'(done_cnt), 256'd0);
    check("rstmid_idle", 256'(busy_w[1]), 256'd0);

    model(230, 5, f_mode, f_mask, esig, eones);
    run(1, 5, -1, 1'b0, cyc);
    check("rerun_cycles", 256'(cyc), 256'd45);
    check("rerun_sig",    256'(sig_w[1]), 256'(esig));
    check("rerun_ones",   256'(ones_w[1]), 256'(eones));
    check("rerun_nvec",   256'(cap.size()), 256'd5);
    if (cap.size() >= 1) check("rerun_vec0", cap[0], exp_q[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_vector_driver.md
Name: sim_vector_driver

Overview:
Sequential stimulus and response end for the generated combinational simulation circuits (N_IN-input, single-output `f`). It generates pseudo-random N_IN-bit input vectors from a 32-bit LFSR and holds each one on the circuit inputs for a programmable settle time. It then samples the circuit output `f` and compacts the responses into a 16-bit CRC signature plus a ones-count. It sits between the simulation test harness (start/num_vectors/result) and one circuit instance.

Parameters:
N_IN, 230, width of driven input vector (≥1)
SEED, 32'h0000_0001, LFSR load value at start; value 0 replaced by 1
LATENCY, 1, cycles each vector is held before sampling f_in (≥1)
COUNT_W, 16, width of vector counter and ones counter

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request; honoured only in IDLE
num_vectors  in  COUNT_W  vectors to apply; sampled on accepted start
vec_out  out  N_IN  vector driven to circuit inputs a0..a(N_IN-1) (bit i -> a_i)
vec_valid  out  1  vec_out is stable and under test
f_in  in  1  circuit output f
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
sig_out  out  16  response signature
ones_count  out  COUNT_W  number of sampled f_in == 1 (wraps modulo 2^COUNT_W)

Behaviour:
- Reset values: vec_out 0, vec_valid 0, busy 0, done 0, sig_out 16'h0000, ones_count 0, FSM IDLE. Asserting rst mid-run aborts immediately to these values; no done pulse.
- WORDS = ceil(N_IN/32). Internal fill register vf is N_IN bits wide.
- LFSR: 32-bit Galois, right shift, mask 32'h8020_0003. Next state: if lfsr[0], (lfsr>>1)^mask; else lfsr>>1.
- FSM states: IDLE, FILL, WAIT, DONE.
- IDLE: start=1 does the following: load lfsr with SEED (or 1 if SEED is 0), sig_out <= 16'hFFFF, ones_count <= 0, latch num_vectors, busy <= 1.
  - If num_vectors == 0, go to DONE.
  - Otherwise go to FILL.
- FILL: lasts exactly WORDS cycles. Each cycle vf <= low N_IN bits of {vf, lfsr}, i.e. shift left 32 and insert the current lfsr in vf[31:0]. The lfsr then advances one step. vec_valid = 0; vec_out holds its previous value.
- On the last FILL cycle edge, vec_out <= the completed vf value, vec_valid <= 1, and the FSM moves to WAIT with the wait counter at 0.
- WAIT: lasts exactly LATENCY cycles. On the final WAIT cycle, f_in is sampled:
  - CRC step: fb = sig[15]^f_in; sig <= {sig[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - ones_count += f_in.
  - The remaining-vector count is decremented.
  - If vectors remain, go to FILL with vec_valid <= 0. Otherwise go to DONE.
- Per-vector period is WORDS+LATENCY cycles; for the defaults this is 9.
- DONE: one cycle with done = 1 and busy = 0. vec_valid <= 0, vec_out is held, and the FSM returns to IDLE.
- sig_out and ones_count hold their values until the next accepted start.
- start outside IDLE is ignored. start in the DONE cycle is ignored.
- No backpressure: f_in is assumed combinationally valid LATENCY cycles after vec_out changes.

Decomposition:
- Package sim_drv_pkg holds:
  - state enum {IDLE, FILL, WAIT, DONE}
  - LFSR_MASK = 32'h8020_0003
  - CRC_POLY = 16'h1021
  - SIG_INIT = 16'hFFFF
  - function words(n) = (n+31)/32
- One sub-module, sim_lfsr32: load, load_val, step, state out.
- The FSM, fill register and signature live in sim_vector_driver.

Test Plan:
- N_IN=32, SEED=1, num_vectors=2, f_in=0 -> first vec_out = 32'h0000_0001; second vec_out = 32'h8020_0003; vec_valid high 1 cycle each.
- Defaults, f_in tied 0, num_vectors=1 -> sig_out = 16'hEFDF, ones_count = 0; done exactly 9 cycles after start is accepted.
- Defaults, f_in tied 1, num_vectors=1 -> sig_out = 16'hFFFE, ones_count = 1.
- Defaults, num_vectors=3, LATENCY=2 -> busy high 30 cycles; done pulses once; start asserted while busy has no effect.
- num_vectors=0 -> done pulses the cycle after start; sig_out = 16'hFFFF, ones_count = 0, vec_valid never asserted.
- rst asserted asynchronously during WAIT of vector 2 of 5 -> all outputs return to their reset values at once, with no done pulse. A new start then runs cleanly and reproduces a fresh-run signature.
